// File: rtl/dm_arb_pkg.sv
// Shared constants and types for the data-memory arbiter.
// Build option: DM_ARB_LOCK_EN enables the grant-lock feature.
package dm_arb_pkg;
  localparam logic       DM_P_CPU = 1'b0;
  localparam logic       DM_P_DMA = 1'b1;
  localparam logic [3:0] BE_NONE  = 4'b0000;
  localparam logic [3:0] BE_WORD  = 4'b1111;

  typedef struct packed {
    logic vld;
    logic rd;
    logic err;
    logic own;
  } dm_rsp_t;
endpackage

// File: rtl/dm_rr_arb2.sv
// Two-way round-robin grant with optional lock (DM_ARB_LOCK_EN).
// Port 0 wins the first tie after reset.
module dm_rr_arb2
  import dm_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic [1:0] i_lock,
  output logic [1:0] o_gnt
);
  logic       r_last;
  logic [1:0] w_req;
  logic [1:0] w_gnt;

`ifdef DM_ARB_LOCK_EN
  logic r_lock_vld;
  logic r_lock_own;
  logic w_locked;

  // A lock only binds while its owner keeps requesting.
  assign w_locked = r_lock_vld & i_req[r_lock_own];

  always_comb begin
    w_req = i_req;
    if (w_locked)
      w_req = r_lock_own ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_vld <= 1'b0;
      r_lock_own <= DM_P_CPU;
    end else if (w_locked) begin
      if (!i_lock[r_lock_own])
        r_lock_vld <= 1'b0;
    end else if (|w_gnt) begin
      r_lock_vld <= |(w_gnt & i_lock);
      r_lock_own <= w_gnt[1];
    end else begin
      r_lock_vld <= 1'b0;
    end
  end
`else
  logic w_lock_unused;
  assign w_lock_unused = ^i_lock;
  assign w_req = i_req;
`endif

  always_comb begin
    unique case (w_req)
      2'b11:   w_gnt = r_last ? 2'b01 : 2'b10;
      default: w_gnt = w_req;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_last <= DM_P_DMA;
    else if (|w_gnt)
      r_last <= w_gnt[1];
  end

  assign o_gnt = w_gnt;
endmodule

// File: rtl/dm_arbiter.sv
// Data-memory arbiter: CPU MEM stage vs debug DMA onto one sync RAM.
// Build option: DM_ARB_LOCK_EN enables pN_lock grant holding.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int MEM_AW = 10,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [3:0]        p0_be,
  input  logic [31:0]       p0_wdata,
  input  logic              p0_lock,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [31:0]       p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [3:0]        p1_be,
  input  logic [31:0]       p1_wdata,
  input  logic              p1_lock,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [31:0]       p1_rdata,
  output logic              p1_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [3:0]        mem_wea,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);
  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_any;
  logic              w_sel;
  logic              w_we;
  logic              w_oor;
  logic [ADDR_W-1:0] w_addr;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic              w_rv;
  logic              w_ev;
  logic              w_addr_unused;
  dm_rsp_t           r_rsp;

  assign w_addr_unused = ^{p0_addr[1:0], p1_addr[1:0]};

  // No grants while reset is held.
  assign w_req = {p1_req, p0_req} & {2{~rst}};

  dm_rr_arb2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .i_req  (w_req),
    .i_lock ({p1_lock, p0_lock}),
    .o_gnt  (w_gnt)
  );

  assign w_any   = |w_gnt;
  assign w_sel   = w_gnt[1];
  assign w_addr  = w_sel ? p1_addr  : p0_addr;
  assign w_we    = w_sel ? p1_we    : p0_we;
  assign w_be    = w_sel ? p1_be    : p0_be;
  assign w_wdata = w_sel ? p1_wdata : p0_wdata;
  assign w_oor   = |w_addr[ADDR_W-1:MEM_AW+2];

  assign mem_addr = w_any ? w_addr[MEM_AW+1:2] : '0;
  assign mem_wea  = (w_any && w_we && !w_oor) ? w_be : BE_NONE;
  assign mem_din  = w_any ? w_wdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp <= '0;
    end else begin
      r_rsp.vld <= w_any;
      r_rsp.rd  <= w_any & ~w_we;
      r_rsp.err <= w_any & w_oor;
      r_rsp.own <= w_sel;
    end
  end

  // Gating with rst drops a response pending when reset arrives.
  assign w_rv = r_rsp.vld & r_rsp.rd  & ~rst;
  assign w_ev = r_rsp.vld & r_rsp.err & ~rst;

  assign p0_gnt    = w_gnt[0];
  assign p1_gnt    = w_gnt[1];
  assign p0_rvalid = w_rv & (r_rsp.own == DM_P_CPU);
  assign p1_rvalid = w_rv & (r_rsp.own == DM_P_DMA);
  assign p0_err    = w_ev & (r_rsp.own == DM_P_CPU);
  assign p1_err    = w_ev & (r_rsp.own == DM_P_DMA);
  assign p0_rdata  = (p0_rvalid && !r_rsp.err) ? mem_dout : '0;
  assign p1_rdata  = (p1_rvalid && !r_rsp.err) ? mem_dout : '0;

  a_p0_hold: assert property (@(posedge clk) disable iff (rst)
    (p0_req && !p0_gnt) |=> (!p0_req ||
      (p0_addr == $past(p0_addr) && p0_we == $past(p0_we))));
  a_p1_hold: assert property (@(posedge clk) disable iff (rst)
    (p1_req && !p1_gnt) |=> (!p1_req ||
      (p1_addr == $past(p1_addr) && p1_we == $past(p1_we))));
endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a response scoreboard.
// Build option: DM_ARB_LOCK_EN selects the locked grant sequence.
module tb_dm_arbiter;
  import dm_arb_pkg::*;

  typedef struct {
    logic        req;
    logic        we;
    logic        lock;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } rq_t;

  typedef struct {
    logic        v0;
    logic        v1;
    logic        e0;
    logic        e1;
    logic [31:0] d0;
    logic [31:0] d1;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_req = 1'b0, p0_we = 1'b0, p0_lock = 1'b0;
  logic [31:0] p0_addr = '0, p0_wdata = '0;
  logic [3:0]  p0_be = '0;
  logic        p1_req = 1'b0, p1_we = 1'b0, p1_lock = 1'b0;
  logic [31:0] p1_addr = '0, p1_wdata = '0;
  logic [3:0]  p1_be = '0;
  logic        p0_gnt, p0_rvalid, p0_err;
  logic        p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_wea;
  logic [31:0] mem_din;
  logic [31:0] mem_dout = '0;

  rsp_t q[$];
  int   errors = 0;
  int   checks = 0;

  dm_arbiter #(.MEM_AW(10), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_be(p0_be),
    .p0_wdata(p0_wdata), .p0_lock(p0_lock), .p0_gnt(p0_gnt),
    .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_be(p1_be),
    .p1_wdata(p1_wdata), .p1_lock(p1_lock), .p1_gnt(p1_gnt),
    .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_addr(mem_addr), .mem_wea(mem_wea), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Sync-read RAM stand-in whose contents are a known function of address.
  always @(posedge clk) mem_dout <= 32'hC0DE0000 ^ {22'd0, mem_addr};

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return 32'hC0DE0000 ^ {22'd0, a[11:2]};
  endfunction

  function automatic rq_t rq(input logic req, input logic we,
                             input logic lock, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] wd);
    rq_t r;
    r.req = req; r.we = we; r.lock = lock;
    r.addr = addr; r.be = be; r.wdata = wd;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic rs, input rq_t a, input rq_t b,
                     input logic [1:0] eg, input string tag);
    rsp_t e;
    rsp_t nx;
    rq_t  g;
    logic oor;
    @(negedge clk);
    rst = rs;
    p0_req = a.req; p0_we = a.we; p0_lock = a.lock;
    p0_addr = a.addr; p0_be = a.be; p0_wdata = a.wdata;
    p1_req = b.req; p1_we = b.we; p1_lock = b.lock;
    p1_addr = b.addr; p1_be = b.be; p1_wdata = b.wdata;
    #1;
    e = '{default: '0};
    if (q.size() > 0) e = q.pop_front();
    if (rs) e = '{default: '0};
    chk({tag, " p0_rvalid"}, p0_rvalid, e.v0);
    chk({tag, " p0_rdata"},  p0_rdata,  e.d0);
    chk({tag, " p0_err"},    p0_err,    e.e0);
    chk({tag, " p1_rvalid"}, p1_rvalid, e.v1);
    chk({tag, " p1_rdata"},  p1_rdata,  e.d1);
    chk({tag, " p1_err"},    p1_err,    e.e1);
    g   = eg[1] ? b : a;
    oor = |g.addr[31:12];
    chk({tag, " p0_gnt"},   p0_gnt,   eg[0]);
    chk({tag, " p1_gnt"},   p1_gnt,   eg[1]);
    chk({tag, " mem_addr"}, mem_addr, (eg != 0) ? g.addr[11:2] : 10'd0);
    chk({tag, " mem_wea"},  mem_wea,
        (eg != 0 && g.we && !oor) ? g.be : BE_NONE);
    chk({tag, " mem_din"},  mem_din,  (eg != 0) ? g.wdata : 32'd0);
    nx = '{default: '0};
    if (eg[0]) begin
      nx.v0 = !g.we;
      nx.e0 = oor;
      nx.d0 = (!g.we && !oor) ? ram_word(g.addr) : 32'd0;
    end
    if (eg[1]) begin
      nx.v1 = !g.we;
      nx.e1 = oor;
      nx.d1 = (!g.we && !oor) ? ram_word(g.addr) : 32'd0;
    end
    q.push_back(nx);
  endtask

  initial begin
    rq_t        I;
    logic [1:0] eg5 [4];
    I = rq(1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
`ifdef DM_ARB_LOCK_EN
    eg5 = '{2'b10, 2'b10, 2'b10, 2'b01};
`else
    eg5 = '{2'b10, 2'b01, 2'b10, 2'b01};
`endif

    cyc(1'b1, I, I, 2'b00, "rst_a");
    cyc(1'b1, I, I, 2'b00, "rst_b");
    cyc(1'b0, I, I, 2'b00, "post_rst");

    cyc(1'b0, rq(1, 1, 0, 32'h10, 4'b0011, 32'h12341234), I, 2'b01, "t1_wr");
    cyc(1'b0, I, I, 2'b00, "t1_idle");

    cyc(1'b1, I, I, 2'b00, "rst_c");
    for (int i = 0; i < 6; i++)
      cyc(1'b0, rq(1, 0, 0, 32'h20, 4'd0, 32'd0),
          rq(1, 0, 0, 32'h44, 4'd0, 32'd0),
          (i % 2 == 0) ? 2'b01 : 2'b10, "t2_alt");
    cyc(1'b0, I, I, 2'b00, "t2_idle");

    cyc(1'b0, I, rq(1, 0, 0, 32'h1000, 4'd0, 32'd0), 2'b10, "t3_rd_oor");
    cyc(1'b0, rq(1, 1, 0, 32'h2000, BE_WORD, 32'hDEADBEEF), I, 2'b01,
        "t3_wr_oor");
    cyc(1'b0, rq(1, 0, 0, 32'hFFF, 4'd0, 32'd0), I, 2'b01, "t3_top_word");
    cyc(1'b0, I, I, 2'b00, "t3_idle");

    for (int i = 0; i < 4; i++)
      cyc(1'b0, I, rq(1, 0, 0, 32'h100 + 32'(4 * i), 4'd0, 32'd0), 2'b10,
          "t6_p1_only");

    cyc(1'b0, rq(1, 0, 0, 32'h30, 4'd0, 32'd0), I, 2'b01, "t5_pre");
    for (int i = 0; i < 4; i++)
      cyc(1'b0, rq(1, 0, 0, 32'h30, 4'd0, 32'd0),
          (i < 3) ? rq(1, 0, 1, 32'h50, 4'd0, 32'd0) : I,
          eg5[i], "t5_lock");
    cyc(1'b0, I, I, 2'b00, "t5_idle");

    cyc(1'b0, rq(1, 0, 0, 32'h40, 4'd0, 32'd0), I, 2'b01, "t4_rd");
    cyc(1'b1, I, I, 2'b00, "t4_rst");
    cyc(1'b0, I, I, 2'b00, "t4_after");
    cyc(1'b0, I, I, 2'b00, "drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
